// File: rtl/clk_reconf_pkg.sv
// Shared types and the DRP preset table for the PLL clock reconfiguration controller.
package clk_reconf_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PLL_RST,
        RD,
        RD_WAIT,
        WR,
        WR_WAIT,
        NEXT,
        LOCK_WAIT,
        ERR
    } state_e;

    // One read-modify-write step: bits set in mask keep the value read back,
    // bits clear in mask are replaced by value.
    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] mask;
        logic [15:0] value;
    } drp_entry_t;

    localparam int         NUM_PRESETS = 4;
    localparam int         NUM_ENTRIES = 4;
    localparam logic [1:0] LAST_ENTRY  = 2'd3;

    // VCO runs at 1600 MHz. Entries program CLKOUT0 (0x08/0x09) and CLKOUT1 (0x0A/0x0B).
    // ClkReg1 keeps the reserved bit 12 and rewrites phase mux, high and low counts.
    // ClkReg2 keeps reserved bits 15:10 and rewrites delay, edge, no_count and mx.
    // Preset 3 uses divide 21 (edge set for the odd split), the nearest integer to 75 MHz.
    localparam drp_entry_t PRESET_TABLE [NUM_PRESETS][NUM_ENTRIES] = '{
        // 50 MHz: divide 32, high 16, low 16
        '{ '{7'h08, 16'h1000, 16'h0410}, '{7'h09, 16'hFC00, 16'h0000},
           '{7'h0A, 16'h1000, 16'h0410}, '{7'h0B, 16'hFC00, 16'h0000} },
        // 25 MHz: divide 64, high 32, low 32
        '{ '{7'h08, 16'h1000, 16'h0820}, '{7'h09, 16'hFC00, 16'h0000},
           '{7'h0A, 16'h1000, 16'h0820}, '{7'h0B, 16'hFC00, 16'h0000} },
        // 100 MHz: divide 16, high 8, low 8
        '{ '{7'h08, 16'h1000, 16'h0208}, '{7'h09, 16'hFC00, 16'h0000},
           '{7'h0A, 16'h1000, 16'h0208}, '{7'h0B, 16'hFC00, 16'h0000} },
        // ~75 MHz: divide 21, high 11, low 10, edge set
        '{ '{7'h08, 16'h1000, 16'h02CA}, '{7'h09, 16'hFC00, 16'h0080},
           '{7'h0A, 16'h1000, 16'h02CA}, '{7'h0B, 16'hFC00, 16'h0080} }
    };

endpackage

// File: rtl/clk_reconf_ctrl_sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops to settle metastability.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/clk_reconf_ctrl.sv
// PLL reconfiguration controller: holds the PLL in reset, rewrites four DRP
// registers from a preset, releases the PLL and waits for lock.
module clk_reconf_ctrl
    import clk_reconf_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 65535,
    parameter int DRP_TIMEOUT  = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic [1:0]  i_sel,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_drp_den,
    output logic        o_drp_dwe,
    output logic [6:0]  o_drp_daddr,
    output logic [15:0] o_drp_di,
    input  logic [15:0] i_drp_do,
    input  logic        i_drp_drdy,
    output logic        o_pll_rst,
    input  logic        i_pll_locked,
    output logic        o_rst_core
);

    localparam int TMO_MAX = (LOCK_TIMEOUT > DRP_TIMEOUT) ? LOCK_TIMEOUT : DRP_TIMEOUT;
    localparam int TW      = $clog2(TMO_MAX + 1);
    localparam logic [TW-1:0] DRP_LIMIT  = TW'(DRP_TIMEOUT - 1);
    localparam logic [TW-1:0] LOCK_LIMIT = TW'(LOCK_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   rdData_q, rdData_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          pllRst_q, pllRst_d;
    logic          rstCore_q, rstCore_d;
    logic          lockSync;
    logic          drpExpired;
    logic          lockExpired;
    drp_entry_t    curEntry;

    sync2 u_lockSync (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .d_i   (i_pll_locked),
        .q_o   (lockSync)
    );

    assign curEntry    = PRESET_TABLE[sel_q][idx_q];
    assign drpExpired  = (tmo_q >= DRP_LIMIT);
    assign lockExpired = (tmo_q >= LOCK_LIMIT);

    // Next-state logic: walk the four entries as read, merge, write, then wait for lock.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sel_d    = sel_q;
        rdData_d = rdData_q;
        err_d    = err_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req) begin
                    sel_d   = i_sel;
                    err_d   = 1'b0;
                    state_d = PLL_RST;
                end
            end
            PLL_RST: begin
                idx_d   = 2'd0;
                state_d = RD;
            end
            RD: state_d = RD_WAIT;
            RD_WAIT: begin
                if (i_drp_drdy) begin
                    rdData_d = (i_drp_do & curEntry.mask) | (curEntry.value & ~curEntry.mask);
                    state_d  = WR;
                end else if (drpExpired) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
            WR: state_d = WR_WAIT;
            WR_WAIT: begin
                if (i_drp_drdy) begin
                    state_d = NEXT;
                end else if (drpExpired) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
            NEXT: begin
                if (idx_q == LAST_ENTRY) begin
                    state_d = LOCK_WAIT;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = RD;
                end
            end
            LOCK_WAIT: begin
                if (lockSync) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (lockExpired) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Timeout counter restarts on every state change and saturates otherwise;
    // PLL reset and core reset are registered from the state being entered.
    always_comb begin
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (tmo_q != '1) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = tmo_q;
        end
        pllRst_d  = state_d inside {PLL_RST, RD, RD_WAIT, WR, WR_WAIT, NEXT};
        rstCore_d = (state_d != IDLE) || !lockSync;
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            sel_q     <= 2'd0;
            rdData_q  <= 16'h0000;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            pllRst_q  <= 1'b1;
            rstCore_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            rdData_q  <= rdData_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            done_q    <= done_d;
            pllRst_q  <= pllRst_d;
            rstCore_q <= rstCore_d;
        end
    end

    assign o_busy      = (state_q != IDLE);
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_drp_den   = (state_q == RD) || (state_q == WR);
    assign o_drp_dwe   = (state_q == WR);
    assign o_drp_daddr = o_drp_den ? curEntry.addr : 7'h00;
    assign o_drp_di    = (state_q == WR) ? rdData_q : 16'h0000;
    assign o_pll_rst   = pllRst_q;
    assign o_rst_core  = rstCore_q;

endmodule

// File: tb/tb_clk_reconf_ctrl.sv
// Scoreboard bench for clk_reconf_ctrl with a latency-3 DRP model.
module tb_clk_reconf_ctrl;

    typedef struct packed {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] di;
    } strobe_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        busy, done, err;
    logic        den, dwe;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic [15:0] drpDo = 16'h0000;
    logic        drdy = 1'b0;
    logic        pllRst;
    logic        locked = 1'b0;
    logic        rstCore;

    int checks = 0;
    int errors = 0;
    int denCount = 0;
    int rdStrobes = 0;
    int doneCount = 0;
    int modelRd = 0;
    int dropAt = 0;
    strobe_t expQ[$];

    clk_reconf_ctrl #(.LOCK_TIMEOUT(100), .DRP_TIMEOUT(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_sel        (sel),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_drp_den    (den),
        .o_drp_dwe    (dwe),
        .o_drp_daddr  (daddr),
        .o_drp_di     (di),
        .i_drp_do     (drpDo),
        .i_drp_drdy   (drdy),
        .o_pll_rst    (pllRst),
        .i_pll_locked (locked),
        .o_rst_core   (rstCore)
    );

    // 100 MHz DRP clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Register contents the DRP model returns on reads.
    function automatic logic [15:0] drpMem(input logic [6:0] a);
        case (a)
            7'h08, 7'h09: return 16'hFFFF;
            7'h0A, 7'h0B: return 16'hA5A5;
            default:      return 16'h0000;
        endcase
    endfunction

    // Hand-computed strobe sequence for preset 1 (25 MHz) against drpMem.
    function automatic strobe_t expSel1(input int k);
        case (k)
            0:       return '{1'b0, 7'h08, 16'h0000};
            1:       return '{1'b1, 7'h08, 16'h1820};
            2:       return '{1'b0, 7'h09, 16'h0000};
            3:       return '{1'b1, 7'h09, 16'hFC00};
            4:       return '{1'b0, 7'h0A, 16'h0000};
            5:       return '{1'b1, 7'h0A, 16'h0820};
            6:       return '{1'b0, 7'h0B, 16'h0000};
            default: return '{1'b1, 7'h0B, 16'hA400};
        endcase
    endfunction

    task automatic pushExpected(input int n);
        for (int k = 0; k < n; k++) expQ.push_back(expSel1(k));
    endtask

    task automatic applyStimulus(input logic [1:0] s);
        sel = s;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic waitPllRstLow(input string name);
        for (int i = 0; i < 300; i++) begin
            if (!pllRst) break;
            @(negedge clk);
        end
        checkOutput(name, 32'(pllRst), 32'd0);
    endtask

    task automatic waitBusyLow(input string name);
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    task automatic doCleanRun(input string tag);
        int dBase;
        int denBase;
        dBase   = doneCount;
        denBase = denCount;
        pushExpected(8);
        applyStimulus(2'd1);
        checkOutput({tag, "_busyPllRst"}, 32'({busy, pllRst, err}), 32'b110);
        waitPllRstLow({tag, "_pllRstFall"});
        repeat (20) @(negedge clk);
        locked = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput({tag, "_doneBusyRstCore"}, 32'({done, busy, rstCore}), 32'b100);
        repeat (5) @(negedge clk);
        checkOutput({tag, "_doneCount"}, 32'(doneCount - dBase), 32'd1);
        checkOutput({tag, "_denCount"}, 32'(denCount - denBase), 32'd8);
        checkOutput({tag, "_queueEmpty"}, 32'(expQ.size()), 32'd0);
        locked = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // DRP model: answers each strobe with drdy three cycles later, optionally dropping one read.
    initial begin : drpModel
        int pend;
        logic [6:0] pendAddr;
        pend = 0;
        pendAddr = 7'h00;
        forever begin
            @(negedge clk);
            drdy = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    drdy  = 1'b1;
                    drpDo = drpMem(pendAddr);
                end
            end else if (den) begin
                pendAddr = daddr;
                if (!dwe) modelRd++;
                if (!dwe && modelRd == dropAt) pend = 0;
                else pend = 3;
            end
        end
    end

    // Monitor: pops the scoreboard on every DRP strobe and counts done pulses.
    initial begin : monitor
        strobe_t e;
        forever begin
            @(negedge clk);
            if (done) doneCount++;
            if (den) begin
                denCount++;
                if (!dwe) rdStrobes++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedStrobe: got we=%0b addr=%0h di=%0h expected none", dwe, daddr, di);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("drpStrobe", 32'({pllRst, dwe, daddr, (dwe ? di : 16'h0000)}), 32'({1'b1, e}));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        int dBase;
        int rdBase;
        int denBase;
        int n;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("resetOutputs", 32'({busy, done, err, den, dwe, daddr, di, pllRst, rstCore}),
                    32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 16'h0000, 1'b1, 1'b1}));
        rst = 1'b0;
        @(negedge clk);
        checkOutput("pllRstAfterReset", 32'({pllRst, rstCore, busy}), 32'b010);

        // Normal reconfiguration with preset 1
        doCleanRun("normal");

        // Lock never arrives
        dBase = doneCount;
        pushExpected(8);
        applyStimulus(2'd1);
        waitPllRstLow("lockTo_pllRstFall");
        n = 0;
        for (int i = 1; i <= 110; i++) begin
            @(negedge clk);
            n = i;
            if (err) break;
        end
        checkOutput("lockTo_errState", 32'({err, busy, rstCore, pllRst}), 32'b1110);
        @(negedge clk);
        n++;
        checkOutput("lockTo_idle", 32'({busy, err, rstCore}), 32'b011);
        checkOutput("lockTo_within103", 32'(n <= 103), 32'd1);
        checkOutput("lockTo_noDone", 32'(doneCount - dBase), 32'd0);
        checkOutput("lockTo_queueEmpty", 32'(expQ.size()), 32'd0);

        // Second read never answered
        rdBase = rdStrobes;
        dropAt = modelRd + 2;
        pushExpected(3);
        applyStimulus(2'd1);
        checkOutput("drpTo_errCleared", 32'(err), 32'd0);
        waitBusyLow("drpTo_idle");
        checkOutput("drpTo_err", 32'({err, rstCore}), 32'b11);
        checkOutput("drpTo_rdStrobes", 32'(rdStrobes - rdBase), 32'd2);
        repeat (10) @(negedge clk);
        checkOutput("drpTo_queueEmpty", 32'(expQ.size()), 32'd0);
        dropAt = 0;

        // Request during WR_WAIT is ignored
        dBase   = doneCount;
        denBase = denCount;
        pushExpected(8);
        applyStimulus(2'd1);
        checkOutput("ignReq_errCleared", 32'(err), 32'd0);
        for (int i = 0; i < 50; i++) begin
            if (den && dwe) break;
            @(negedge clk);
        end
        checkOutput("ignReq_firstWrite", 32'({den, dwe}), 32'b11);
        @(negedge clk);
        applyStimulus(2'd2);
        waitPllRstLow("ignReq_pllRstFall");
        repeat (20) @(negedge clk);
        locked = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("ignReq_doneBusy", 32'({done, busy, rstCore}), 32'b100);
        repeat (30) @(negedge clk);
        checkOutput("ignReq_singleDone", 32'(doneCount - dBase), 32'd1);
        checkOutput("ignReq_denCount", 32'(denCount - denBase), 32'd8);
        checkOutput("ignReq_stillIdle", 32'(busy), 32'd0);
        locked = 1'b0;
        repeat (5) @(negedge clk);

        // Reset while a read is pending
        denBase = denCount;
        pushExpected(1);
        applyStimulus(2'd1);
        for (int i = 0; i < 20; i++) begin
            if (den) break;
            @(negedge clk);
        end
        checkOutput("rstRd_firstRead", 32'({den, dwe}), 32'b10);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstRd_resetOutputs", 32'({busy, done, err, den, dwe, daddr, di, pllRst, rstCore}),
                    32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 16'h0000, 1'b1, 1'b1}));
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstRd_pllRstFall", 32'(pllRst), 32'd0);
        repeat (10) @(negedge clk);
        checkOutput("rstRd_noWrite", 32'(denCount - denBase), 32'd1);
        checkOutput("rstRd_queueEmpty", 32'(expQ.size()), 32'd0);
        doCleanRun("afterRst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
